// File: rtl/fixed_alu_sequencer.sv
// Fixed-point ALU command sequencer: queues Q16.16 commands in a small FIFO,
// issues them one at a time over a start/done handshake, and returns the
// result plus flags on a valid/ready response port.
module fixed_alu_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [3:0]  cmd_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_start,
    input  logic [31:0] alu_result,
    input  logic        alu_done,
    input  logic        alu_ovf,
    input  logic        alu_unf,
    input  logic        alu_dbz,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] b;
        logic [31:0] a;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    cmd_t        mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    logic [7:0]  cnt;

    // Pointer MSB acts as a lap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign alu_start = (state_q == ISSUE);
    assign busy      = (state_q != IDLE) || !empty;

    // FIFO pointers; pop only sees entries written on an earlier edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, b: cmd_b, a: cmd_a};
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; done takes priority over the timeout in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!empty) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (alu_done || cnt == TO_CNT) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU operand registers: loaded on pop, held until the next pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (pop) begin
            alu_a  <= mem[rd_ptr[AW-1:0]].a;
            alu_b  <= mem[rd_ptr[AW-1:0]].b;
            alu_op <= mem[rd_ptr[AW-1:0]].op;
        end
    end

    // Wait-cycle counter: cleared on issue, counts while waiting for done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   cnt <= '0;
        else if (state_q == ISSUE)      cnt <= '0;
        else if (state_q == WAIT && !alu_done && cnt != TO_CNT)
                                        cnt <= cnt + 8'd1;
    end

    // Response capture; done wins over timeout, stray done elsewhere ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (state_q == WAIT) begin
                if (alu_done) begin
                    rsp_result <= alu_result;
                    rsp_flags  <= {1'b0, alu_dbz, alu_unf, alu_ovf};
                    rsp_valid  <= 1'b1;
                end else if (cnt == TO_CNT) begin
                    rsp_result <= '0;
                    rsp_flags  <= 4'b1000;
                    rsp_valid  <= 1'b1;
                end
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_alu_sequencer.sv
// Directed bench for fixed_alu_sequencer with a 3-edge nominal ALU stub.
module tb_fixed_alu_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_op = '0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic [31:0] alu_result;
    logic        alu_done, alu_ovf, alu_unf, alu_dbz;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;

    // ALU stub controls
    logic       hang = 1'b0;
    logic       stray = 1'b0;
    logic [2:0] sr;
    logic [31:0] model_res;

    fixed_alu_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_done(alu_done),
        .alu_ovf(alu_ovf), .alu_unf(alu_unf), .alu_dbz(alu_dbz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stub: done three edges after start is first seen high.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= {sr[1:0], alu_start};
    end

    always @(posedge clk) if (alu_start) start_cnt <= start_cnt + 1;

    // op 0 ADD, 1 SUB, 3 DIV (result 0 on divide by zero)
    always_comb begin
        model_res = '0;
        case (alu_op)
            4'd0: model_res = alu_a + alu_b;
            4'd1: model_res = alu_a - alu_b;
            4'd3: model_res = (alu_b == 0) ? 32'h0 : 32'(({{32{alu_a[31]}}, alu_a} << 16) / {{32{alu_b[31]}}, alu_b});
            default: model_res = '0;
        endcase
    end

    assign alu_done   = (sr[2] && !hang) || stray;
    assign alu_result = stray ? 32'hDEADBEEF : model_res;
    assign alu_ovf    = stray;
    assign alu_unf    = 1'b0;
    assign alu_dbz    = !stray && (alu_op == 4'd3) && (alu_b == 0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns the number of edges until rsp_valid; bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout_bound", 32'(rsp_valid), 32'd1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int s0;

        // Reset
        #12;
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);

        // Single ADD: 1.0 + 2.0
        s0 = start_cnt;
        push(32'h0001_0000, 32'h0002_0000, 4'd0);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_start_idle", 32'(alu_start), 32'd0);
        tick();
        chk("add_start_high", 32'(alu_start), 32'd1);
        chk("add_alu_a", alu_a, 32'h0001_0000);
        tick();
        chk("add_start_low", 32'(alu_start), 32'd0);
        wait_rsp(n);
        chk("add_latency", 32'(n + 2), 32'd5);
        chk("add_result", rsp_result, 32'h0003_0000);
        chk("add_flags", 32'(rsp_flags), 32'h0);
        chk("add_one_start", 32'(start_cnt - s0), 32'd1);
        accept();
        chk("add_rsp_cleared", 32'(rsp_valid), 32'd0);

        // DIV by zero followed by a queued SUB
        push(32'h0005_0000, 32'h0000_0000, 4'd3);
        push(32'h0003_0000, 32'h0001_0000, 4'd1);
        wait_rsp(n);
        chk("dbz_flags", 32'(rsp_flags), 32'h4);
        chk("dbz_result", rsp_result, 32'h0);
        accept();
        wait_rsp(n);
        chk("sub_result", rsp_result, 32'h0002_0000);
        chk("sub_flags", 32'(rsp_flags), 32'h0);
        chk("sub_alu_op", 32'(alu_op), 32'd1);
        accept();

        // Fill: DEPTH+1 back-to-back accepts with responses blocked
        for (int i = 1; i <= DEPTH + 1; i++) begin
            chk("fill_ready_before", 32'(cmd_ready), 32'd1);
            push(32'(i) << 16, 32'h0001_0000, 4'd0);
        end
        chk("fill_ready_dropped", 32'(cmd_ready), 32'd0);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            wait_rsp(n);
            chk("fill_order", rsp_result, 32'(i + 1) << 16);
            accept();
        end
        chk("fill_drained_busy", 32'(busy), 32'd0);

        // Timeout: ALU never answers
        hang = 1'b1;
        push(32'h0001_0000, 32'h0001_0000, 4'd0);
        wait_rsp(n);
        chk("to_latency", 32'(n), 32'(TIMEOUT + 3));
        chk("to_result", rsp_result, 32'h0);
        chk("to_flags", 32'(rsp_flags), 32'h8);
        accept();
        hang = 1'b0;
        tick();

        // Backpressure with a stray done while in RESP
        push(32'h0007_0000, 32'h0001_0000, 4'd0);
        wait_rsp(n);
        chk("bp_latency", 32'(n), 32'd5);
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("bp_valid_held", 32'(rsp_valid), 32'd1);
        chk("bp_result_held", rsp_result, 32'h0008_0000);
        chk("bp_flags_held", 32'(rsp_flags), 32'h0);
        accept();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (4) tick();
        chk("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Reset during WAIT with a second command queued
        push(32'h0001_0000, 32'h0001_0000, 4'd0);
        push(32'h0002_0000, 32'h0001_0000, 4'd0);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start", 32'(alu_start), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_dropped_busy", 32'(busy), 32'd0);
        push(32'h0004_0000, 32'h0001_0000, 4'd1);
        wait_rsp(n);
        chk("post_rst_latency", 32'(n), 32'd5);
        chk("post_rst_result", rsp_result, 32'h0003_0000);
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
